// File: rtl/dmem_bus_if.sv
// dmem_bus_if
//    Data-memory bus interface sitting directly after the MEM stage. A
//    combinational MEM-stage request is latched and run as a multi-cycle
//    req/ack transaction on the external data bus; the pipeline is stalled
//    until the access completes, errors or times out. The read word is
//    returned to the MEM stage for lane extraction.
//
//    state | meaning
//    IDLE  | waiting for mem_ce_i; latches the request when it arrives
//    BUSY  | bus_req_o asserted, waiting for ack / err / timeout
//    DONE  | one non-stalled cycle; result and err_o presented
//
// Ports
//    clk, rst                 clock, synchronous active-high reset
//    mem_ce_i/we_i/sel_i      MEM-stage access enable, write, byte lanes
//    mem_addr_i, mem_data_i   MEM-stage byte address and write data
//    mem_data_o               read word back to the MEM stage
//    stallreq_o               stall request to the pipeline controller
//    err_o                    one-cycle pulse on bus error or timeout
//    bus_req_o/we_o/addr_o/sel_o/wdata_o   external bus request
//    bus_ack_i, bus_err_i, bus_rdata_i      external bus response

module dmem_bus_if #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        stallreq_o,
   output logic        err_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic        bus_err_i,
   input  logic [31:0] bus_rdata_i
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Last counter value before the forced completion fires.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nxt;
   logic        we_q, we_nxt;
   logic [3:0]  sel_q, sel_nxt;
   logic [31:0] addr_q, addr_nxt;
   logic [31:0] wdata_q, wdata_nxt;
   logic [31:0] rdata_q, rdata_nxt;
   logic        err_q, err_nxt;
   logic [7:0]  cnt_q, cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         we_q    <= 1'b0;
         sel_q   <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state   <= state_nxt;
         we_q    <= we_nxt;
         sel_q   <= sel_nxt;
         addr_q  <= addr_nxt;
         wdata_q <= wdata_nxt;
         rdata_q <= rdata_nxt;
         err_q   <= err_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      we_nxt    = we_q;
      sel_nxt   = sel_q;
      addr_nxt  = addr_q;
      wdata_nxt = wdata_q;
      rdata_nxt = rdata_q;
      err_nxt   = err_q;
      cnt_nxt   = cnt_q;
      case (state)
         S_IDLE: begin
            if (mem_ce_i) begin
               we_nxt    = mem_we_i;
               sel_nxt   = mem_sel_i;
               // Masking keeps the bus address word aligned.
               addr_nxt  = mem_addr_i & ~32'h3;
               wdata_nxt = mem_data_i;
               cnt_nxt   = 8'd0;
               err_nxt   = 1'b0;
               state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (bus_err_i) begin
               rdata_nxt = 32'd0;
               err_nxt   = 1'b1;
               state_nxt = S_DONE;
            end else if (bus_ack_i) begin
               if (!we_q) begin
                  rdata_nxt = bus_rdata_i;
               end
               state_nxt = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               rdata_nxt = 32'd0;
               err_nxt   = 1'b1;
               state_nxt = S_DONE;
            end else begin
               cnt_nxt = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            err_nxt   = 1'b0;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // bus_req_o decodes the state register so a reset in BUSY drops it at that edge.
   assign bus_req_o   = (state == S_BUSY);
   assign bus_we_o    = we_q;
   assign bus_addr_o  = addr_q;
   assign bus_sel_o   = sel_q;
   assign bus_wdata_o = wdata_q;
   assign mem_data_o  = rdata_q;
   assign err_o       = (state == S_DONE) && err_q;
   // Stall is raised in the very cycle the request appears, before it is latched.
   assign stallreq_o  = !rst && ((state == S_BUSY) || ((state == S_IDLE) && mem_ce_i));

endmodule
